// File: rtl/kfpga_config_pkg.sv
// Shared definitions for kfpga configuration loaders: FSM state encoding and
// the word-count helper used to size bitstream counters.
package kfpga_config_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_COMMIT = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    function automatic int ceil_div(input int num, input int den);
        return (num + den - 1) / den;
    endfunction

endpackage

// File: rtl/config_loader.sv
// Bitstream loader: collects words into a shadow register over valid/ready and
// commits the full image to config_out in one cycle, so tiles never see a partial load.
module config_loader
    import kfpga_config_pkg::*;
#(
    parameter int CONFIG_WIDTH = 12,
    parameter int WORD_WIDTH   = 8
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    start,
    input  logic                    abort,
    input  logic [WORD_WIDTH-1:0]   data_in,
    input  logic                    data_valid,
    output logic                    data_ready,
    output logic [CONFIG_WIDTH-1:0] config_out,
    output logic                    config_valid,
    output logic                    busy
);

    localparam int WORDS = ceil_div(CONFIG_WIDTH, WORD_WIDTH);
    localparam int CNT_W = $clog2(WORDS + 1);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WORDS - 1);

    state_t                  r_state;
    logic [CNT_W-1:0]        r_count;
    logic [CONFIG_WIDTH-1:0] r_shadow;
    logic [CONFIG_WIDTH-1:0] r_config;
    logic                    r_valid;
    logic                    r_busy;
    logic [CONFIG_WIDTH-1:0] w_shadow_next;
    logic                    w_accept;

    assign data_ready   = (r_state == ST_LOAD) && !abort;
    assign w_accept     = data_ready && data_valid;
    assign config_out   = r_config;
    assign config_valid = r_valid;
    assign busy         = r_busy;

    // Each word owns a fixed slice of the shadow; the last slice may be narrower
    // than a word, in which case the surplus high bits of data_in are dropped.
    generate
        for (genvar gi = 0; gi < WORDS; gi++) begin : g_word
            localparam int LO  = gi * WORD_WIDTH;
            localparam int HI  = ((gi + 1) * WORD_WIDTH > CONFIG_WIDTH) ?
                                 CONFIG_WIDTH - 1 : (gi + 1) * WORD_WIDTH - 1;
            localparam int W_I = HI - LO + 1;

            assign w_shadow_next[HI:LO] = (w_accept && (r_count == CNT_W'(gi))) ?
                                          data_in[W_I-1:0] : r_shadow[HI:LO];
        end
    endgenerate

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_count  <= '0;
            r_shadow <= '0;
            r_config <= '0;
            r_valid  <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            unique case (r_state)
                ST_IDLE, ST_DONE: begin
                    // start also retires a committed image: it stays visible but stale
                    if (start) begin
                        r_state  <= ST_LOAD;
                        r_count  <= '0;
                        r_shadow <= '0;
                        r_valid  <= 1'b0;
                        r_busy   <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    if (abort) begin
                        r_state  <= ST_IDLE;
                        r_count  <= '0;
                        r_shadow <= '0;
                        r_busy   <= 1'b0;
                    end else if (w_accept) begin
                        r_shadow <= w_shadow_next;
                        if (r_count == LAST_IDX) begin
                            r_state <= ST_COMMIT;
                            r_count <= '0;
                        end else begin
                            r_count <= r_count + 1'b1;
                        end
                    end
                end
                ST_COMMIT: begin
                    r_config <= r_shadow;
                    r_valid  <= 1'b1;
                    r_busy   <= 1'b0;
                    r_state  <= ST_DONE;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/config_loader.md
# config_loader

Configuration loader for the kfpga fabric. It accepts a bitstream as a word stream over a valid/ready handshake and assembles it in an internal shadow register. It then commits the whole image atomically to the parallel `config_out` bus that feeds the tiles' `config_in` ports, such as IOTile and the multiplexer select bits. Tiles never see a partially loaded configuration.

## Interface

Parameters:
- `CONFIG_WIDTH`, 12: total configuration bits driven on `config_out`, ≥ 1.
- `WORD_WIDTH`, 8: bits per bitstream word, ≥ 1.
- Derived `WORDS` = ceil(CONFIG_WIDTH / WORD_WIDTH).

Ports:
- `clock`, in, 1: the single clock; all state changes on its rising edge.
- `reset`, in, 1: asynchronous, active-high reset.
- `start`, in, 1: begins a load when the block is in IDLE or DONE.
- `abort`, in, 1: cancels a load in progress.
- `data_in`, in, WORD_WIDTH: bitstream word.
- `data_valid`, in, 1: `data_in` is valid.
- `data_ready`, out, 1: the block accepts `data_in` this cycle.
- `config_out`, out, CONFIG_WIDTH: committed configuration to the fabric.
- `config_valid`, out, 1: `config_out` holds a fully committed image.
- `busy`, out, 1: state is LOAD or COMMIT.

## Operation

- **States:** IDLE, LOAD, COMMIT, DONE.
- **IDLE:**
  - `start` → LOAD; word counter cleared, shadow cleared to 0.
- **LOAD:**
  - `data_ready` = ~`abort` (combinational).
  - A word is accepted on a cycle with `data_valid & data_ready`.
  - Word i (0-based) is written to shadow bits [i*WORD_WIDTH +: WORD_WIDTH].
  - For the final word, bits above CONFIG_WIDTH-1 are discarded.
  - Counter increments per accepted word. Acceptance of word WORDS-1 → COMMIT.
  - `start` is ignored in LOAD.
- **abort in LOAD:**
  - → IDLE. The word on that cycle is not accepted; the shadow is discarded.
  - `config_out` and `config_valid` keep their previous values.
- **COMMIT:** one cycle. `config_out` ← shadow, `config_valid` ← 1, → DONE. `abort` is ignored in COMMIT.
- **DONE:**
  - Holds `config_out`.
  - `start` → LOAD, and `config_valid` drops to 0 on that edge. The old image stays on `config_out` but is flagged stale.
  - `abort` in DONE has no effect.
- **Counter:** width clog2(WORDS+1); never exceeds WORDS-1 in LOAD.
- **Reset values:**
  - state IDLE, `config_out` = 0, `config_valid` = 0, `busy` = 0, `data_ready` = 0.
  - Counter and shadow = 0.

## Timing

- `data_ready` is 0 in every state except LOAD. It is never asserted in COMMIT, so the source must not expect back-to-back images without a new `start`.
- Throughput: one word per cycle while `data_valid` is held high.
- Latency: last word accepted at edge k → COMMIT during cycle k..k+1 → `config_out` and `config_valid` update at edge k+1.
- Full load of WORDS words with continuous valid: `start` at edge s, words at edges s+1..s+WORDS, `config_valid` high after edge s+WORDS+1.
- Reset asserted mid-LOAD or mid-COMMIT: all state returns immediately (asynchronously) to reset values. No partial commit is possible.
- `start` and `abort` together in IDLE/DONE: `start` wins (abort has no effect outside LOAD).

## Structure

- Shared package `kfpga_config_pkg`:
  - state encoding (IDLE=0, LOAD=1, COMMIT=2, DONE=3);
  - a `ceil_div` function used for `WORDS`.
  - Future tile loaders reuse it.
- Single module, no sub-module. Counter, shadow and FSM are inline.

## Test plan

- **Two-word load:** defaults (12/8), `start`, words 0xA5 then 0xFC with continuous valid.
  - → `config_out` = 0xCA5 (upper nibble of 0xFC dropped).
  - `config_valid` rises 1 cycle after the 2nd acceptance; `busy` is high for 3 cycles.
- **Source stalls:** `data_valid` toggled 1/0.
  - → only valid cycles are accepted; image is identical to the first scenario; `config_out` stays 0 until commit.
- **Abort and reload:**
  - `abort` asserted on the cycle the 2nd word is valid → `data_ready` = 0 that cycle, state IDLE, `config_out` unchanged.
  - Then a full reload of 0x12, 0x03 → `config_out` = 0x312.
- **Reload from DONE:** after 0xCA5 is committed, `start`.
  - → `config_valid` = 0 next cycle, `config_out` still 0xCA5 until the new commit.
  - New image 0xFF, 0x0F → 0xFFF.
- **Async reset:** assert `reset` between edges mid-LOAD.
  - → outputs go to reset values before the next edge.
  - After release, the block is idle and ignores `data_valid` until `start`.
- **IOTile-sized config:** `CONFIG_WIDTH`=4, `WORD_WIDTH`=1, words 1,0,1,1 → `config_out` = 0b1101, committed 1 cycle after the 4th word.
